ysyx_mem_arbiter: RTL and testbench

Two-master arbiter that shares the single AXI4-Lite memory port between the IFU (read-only instruction fetch) and the LSU (data read/write). It sits between the core's fetch/load-store units and the SoC bus. Grants are round-robin, one transaction at a time, and the granted address, data and strobe are latched so downstream signals stay stable regardless of upstream behaviour. Responses are routed back to the granted master as one-cycle pulses.

---
 rtl/ysyx_mem_arbiter_pkg.sv | 21 ++
 rtl/ysyx_mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_ysyx_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_mem_arbiter_pkg.sv
// rtl/ysyx_mem_arbiter_pkg.sv - shared state encodings and bus constants for the memory arbiter
package ysyx_mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_IFU_AR = 3'd1,
    ST_IFU_R  = 3'd2,
    ST_LSU_AR = 3'd3,
    ST_LSU_R  = 3'd4,
    ST_LSU_W  = 3'd5,
    ST_LSU_B  = 3'd6
  } arb_state_e;

  typedef enum logic {
    GRANT_IFU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/ysyx_mem_arbiter.sv
// rtl/ysyx_mem_arbiter.sv - round-robin IFU/LSU arbiter onto one AXI4-Lite master port
module ysyx_mem_arbiter
  import ysyx_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic                ifu_arvalid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic                ifu_rvalid,
  output logic                ifu_err,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic                lsu_arvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                lsu_rvalid,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic                lsu_wvalid,
  output logic                lsu_bvalid,
  output logic                lsu_err,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready
);

  arb_state_e          state_q;
  grant_e              last_grant_q;
  logic                aw_done_q;
  logic                w_done_q;
  logic [ADDR_W-1:0]   m_araddr_q;
  logic [ADDR_W-1:0]   m_awaddr_q;
  logic [DATA_W-1:0]   m_wdata_q;
  logic [DATA_W/8-1:0] m_wstrb_q;
  logic                m_arvalid_q;
  logic                m_awvalid_q;
  logic                m_wvalid_q;
  logic                m_rready_q;
  logic                m_bready_q;

  logic ifu_cand;
  logic lsu_cand;
  logic grant_ifu;
  logic grant_lsu;
  logic aw_fire;
  logic w_fire;
  logic aw_done_d;
  logic w_done_d;

  // Round-robin pick: a lone candidate wins, a tie goes to whoever was not granted last.
  always_comb begin
    ifu_cand  = ifu_arvalid;
    lsu_cand  = lsu_wvalid | lsu_arvalid;
    grant_ifu = ifu_cand & (~lsu_cand | (last_grant_q == GRANT_LSU));
    grant_lsu = lsu_cand & ~grant_ifu;
    aw_fire   = m_awvalid_q & m_awready;
    w_fire    = m_wvalid_q & m_wready;
    aw_done_d = aw_done_q | aw_fire;
    w_done_d  = w_done_q | w_fire;
  end

  // Arbiter FSM: latch the winner's request on grant, then walk its channel handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_LSU;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      m_araddr_q   <= '0;
      m_awaddr_q   <= '0;
      m_wdata_q    <= '0;
      m_wstrb_q    <= '0;
      m_arvalid_q  <= 1'b0;
      m_awvalid_q  <= 1'b0;
      m_wvalid_q   <= 1'b0;
      m_rready_q   <= 1'b0;
      m_bready_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_ifu) begin
            last_grant_q <= GRANT_IFU;
            m_araddr_q   <= ifu_araddr;
            m_arvalid_q  <= 1'b1;
            state_q      <= ST_IFU_AR;
          end else if (grant_lsu) begin
            last_grant_q <= GRANT_LSU;
            // A pending store takes priority; a parallel load waits for a later grant.
            if (lsu_wvalid) begin
              m_awaddr_q  <= lsu_awaddr;
              m_wdata_q   <= lsu_wdata;
              m_wstrb_q   <= lsu_wstrb;
              m_awvalid_q <= 1'b1;
              m_wvalid_q  <= 1'b1;
              aw_done_q   <= 1'b0;
              w_done_q    <= 1'b0;
              state_q     <= ST_LSU_W;
            end else begin
              m_araddr_q  <= lsu_araddr;
              m_arvalid_q <= 1'b1;
              state_q     <= ST_LSU_AR;
            end
          end
        end
        ST_IFU_AR, ST_LSU_AR: begin
          if (m_arready) begin
            m_arvalid_q <= 1'b0;
            m_rready_q  <= 1'b1;
            state_q     <= (state_q == ST_IFU_AR) ? ST_IFU_R : ST_LSU_R;
          end
        end
        ST_IFU_R, ST_LSU_R: begin
          if (m_rvalid) begin
            m_rready_q <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        ST_LSU_W: begin
          if (aw_fire) m_awvalid_q <= 1'b0;
          if (w_fire)  m_wvalid_q  <= 1'b0;
          if (aw_done_d && w_done_d) begin
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            m_bready_q <= 1'b1;
            state_q    <= ST_LSU_B;
          end else begin
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
          end
        end
        ST_LSU_B: begin
          if (m_bvalid) begin
            m_bready_q <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Response routing: pulses are qualified by the owning state and suppressed during reset.
  always_comb begin
    ifu_rvalid = ~rst & (state_q == ST_IFU_R) & m_rvalid;
    lsu_rvalid = ~rst & (state_q == ST_LSU_R) & m_rvalid;
    lsu_bvalid = ~rst & (state_q == ST_LSU_B) & m_bvalid;
    ifu_rdata  = ifu_rvalid ? m_rdata : '0;
    lsu_rdata  = lsu_rvalid ? m_rdata : '0;
    ifu_err    = ifu_rvalid & (m_rresp != RESP_OKAY);
    lsu_err    = (lsu_rvalid & (m_rresp != RESP_OKAY)) | (lsu_bvalid & (m_bresp != RESP_OKAY));
  end

  assign m_araddr  = m_araddr_q;
  assign m_arvalid = m_arvalid_q;
  assign m_rready  = m_rready_q;
  assign m_awaddr  = m_awaddr_q;
  assign m_awvalid = m_awvalid_q;
  assign m_wdata   = m_wdata_q;
  assign m_wstrb   = m_wstrb_q;
  assign m_wvalid  = m_wvalid_q;
  assign m_bready  = m_bready_q;

endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// tb/tb_ysyx_mem_arbiter.sv - directed scoreboard bench for the IFU/LSU memory arbiter
module tb_ysyx_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic [31:0] ifu_rdata;
  logic        ifu_rvalid;
  logic        ifu_err;
  logic [31:0] lsu_araddr;
  logic        lsu_arvalid;
  logic [31:0] lsu_rdata;
  logic        lsu_rvalid;
  logic [31:0] lsu_awaddr;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wstrb;
  logic        lsu_wvalid;
  logic        lsu_bvalid;
  logic        lsu_err;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;
  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;

  ysyx_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid),
    .ifu_rdata(ifu_rdata), .ifu_rvalid(ifu_rvalid), .ifu_err(ifu_err),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid),
    .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
    .lsu_awaddr(lsu_awaddr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid),
    .lsu_bvalid(lsu_bvalid), .lsu_err(lsu_err),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = IFU read, 1 = LSU read, 2 = LSU write
  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  function automatic resp_t mk(input logic [1:0] k, input logic [31:0] d, input logic e);
    resp_t r;
    r.kind = k;
    r.data = d;
    r.err  = e;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every upstream pulse must match the oldest scoreboard entry.
  logic [1:0]  mon_kind;
  logic [31:0] mon_data;
  resp_t       mon_e;
  always @(negedge clk) begin
    if (ifu_rvalid || lsu_rvalid || lsu_bvalid || ifu_err || lsu_err) begin
      mon_kind = ifu_rvalid ? 2'd0 : lsu_rvalid ? 2'd1 : lsu_bvalid ? 2'd2 : 2'd3;
      mon_data = ifu_rvalid ? ifu_rdata : lsu_rvalid ? lsu_rdata : 32'h0;
      n_checks++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_pulse: observed kind %0d data %0h expected no response", mon_kind, mon_data);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("resp_kind", {62'd0, mon_kind}, {62'd0, mon_e.kind});
        chk("resp_data", {32'd0, mon_data}, {32'd0, mon_e.data});
        chk("resp_err", {62'd0, ifu_err, lsu_err},
            {62'd0, (mon_e.kind == 2'd0) ? {mon_e.err, 1'b0} : {1'b0, mon_e.err}});
      end
    end
  end

  // Slave side of one read; entered during the IDLE cycle in which the request is presented.
  task automatic slave_read(input logic [31:0] addr, input int ar_delay,
                            input logic [31:0] rdata, input logic [1:0] rresp, input int r_delay);
    int t;
    #2;
    chk("ar_latency_idle", {63'd0, m_arvalid}, 64'd0);
    t = 0;
    while (!m_arvalid && t < 8) begin
      cyc();
      #2;
      t++;
    end
    chk("ar_seen", {63'd0, m_arvalid}, 64'd1);
    for (int i = 0; i < ar_delay; i++) begin
      chk("ar_hold_addr", {32'd0, m_araddr}, {32'd0, addr});
      chk("ar_hold_valid", {63'd0, m_arvalid}, 64'd1);
      cyc();
      #2;
    end
    m_arready = 1'b1;
    chk("ar_addr", {32'd0, m_araddr}, {32'd0, addr});
    cyc();
    m_arready = 1'b0;
    #2;
    chk("r_phase", {62'd0, m_arvalid, m_rready}, 64'd1);
    for (int i = 0; i < r_delay; i++) begin
      cyc();
      #2;
      chk("r_wait_rready", {63'd0, m_rready}, 64'd1);
    end
    m_rdata  = rdata;
    m_rresp  = rresp;
    m_rvalid = 1'b1;
  endtask

  // Slave side of one write; readies pulse on their own delay counts from first AW/W valid.
  task automatic slave_write(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                             input int aw_delay, input int w_delay, input logic [1:0] bresp);
    int t;
    int last;
    #2;
    chk("aw_latency_idle", {62'd0, m_awvalid, m_wvalid}, 64'd0);
    t = 0;
    while (!m_awvalid && t < 8) begin
      cyc();
      #2;
      t++;
    end
    chk("aw_w_seen", {62'd0, m_awvalid, m_wvalid}, 64'd3);
    last = (aw_delay > w_delay) ? aw_delay : w_delay;
    for (int c = 0; c <= last; c++) begin
      m_awready = (c == aw_delay);
      m_wready  = (c == w_delay);
      if (c <= aw_delay) begin
        chk("aw_hold", {31'd0, m_awvalid, m_awaddr}, {31'd0, 1'b1, addr});
      end else begin
        chk("aw_dropped", {63'd0, m_awvalid}, 64'd0);
      end
      if (c <= w_delay) begin
        chk("w_hold", {27'd0, m_wvalid, m_wstrb, m_wdata}, {27'd0, 1'b1, wstrb, wdata});
      end else begin
        chk("w_dropped", {63'd0, m_wvalid}, 64'd0);
      end
      cyc();
      #2;
    end
    m_awready = 1'b0;
    m_wready  = 1'b0;
    chk("b_phase", {60'd0, m_bready, m_awvalid, m_wvalid, m_arvalid}, 64'h8);
    m_bresp  = bresp;
    m_bvalid = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ifu_araddr = '0; ifu_arvalid = 1'b0;
    lsu_araddr = '0; lsu_arvalid = 1'b0;
    lsu_awaddr = '0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 1'b0;
    m_arready = 1'b0; m_rdata = '0; m_rresp = '0; m_rvalid = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_bresp = '0; m_bvalid = 1'b0;
    repeat (3) cyc();
    #2;
    chk("rst_valids", {59'd0, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 64'd0);
    chk("rst_upstream", {59'd0, ifu_rvalid, lsu_rvalid, lsu_bvalid, ifu_err, lsu_err}, 64'd0);
    chk("rst_addr", {m_araddr, m_awaddr}, 64'd0);
    chk("rst_wdata", {28'd0, m_wstrb, m_wdata}, 64'd0);
    rst = 1'b0;

    // IFU alone, arready after 2 cycles
    cyc();
    ifu_araddr  = 32'h8000_0000;
    ifu_arvalid = 1'b1;
    sb.push_back(mk(2'd0, 32'h0000_0413, 1'b0));
    slave_read(32'h8000_0000, 2, 32'h0000_0413, 2'b00, 1);
    cyc();
    m_rvalid = 1'b0; ifu_arvalid = 1'b0;

    // Tie after reset: IFU, then LSU, then IFU re-request loses the next tie
    do_reset();
    ifu_araddr = 32'h8000_0004; ifu_arvalid = 1'b1;
    lsu_araddr = 32'h8000_2000; lsu_arvalid = 1'b1;
    sb.push_back(mk(2'd0, 32'h1111_0001, 1'b0));
    sb.push_back(mk(2'd1, 32'h2222_0002, 1'b0));
    sb.push_back(mk(2'd0, 32'h3333_0003, 1'b0));
    slave_read(32'h8000_0004, 0, 32'h1111_0001, 2'b00, 0);
    cyc();
    m_rvalid = 1'b0; ifu_araddr = 32'h8000_0008;
    slave_read(32'h8000_2000, 1, 32'h2222_0002, 2'b00, 0);
    cyc();
    m_rvalid = 1'b0; lsu_arvalid = 1'b0;
    slave_read(32'h8000_0008, 0, 32'h3333_0003, 2'b00, 2);
    cyc();
    m_rvalid = 1'b0; ifu_arvalid = 1'b0;

    // Store with wready three cycles ahead of awready
    lsu_awaddr = 32'h8000_1000; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF; lsu_wvalid = 1'b1;
    sb.push_back(mk(2'd2, 32'h0, 1'b0));
    slave_write(32'h8000_1000, 32'hDEAD_BEEF, 4'hF, 3, 0, 2'b00);
    cyc();
    m_bvalid = 1'b0; lsu_wvalid = 1'b0;

    // Store with same-cycle aw/w handshake and an error response
    lsu_awaddr = 32'h8000_1004; lsu_wdata = 32'h1234_5678; lsu_wstrb = 4'b0011; lsu_wvalid = 1'b1;
    sb.push_back(mk(2'd2, 32'h0, 1'b1));
    slave_write(32'h8000_1004, 32'h1234_5678, 4'b0011, 1, 1, 2'b11);
    cyc();
    m_bvalid = 1'b0; m_bresp = 2'b00; lsu_wvalid = 1'b0;

    // LSU read with SLVERR
    lsu_araddr = 32'h8000_3000; lsu_arvalid = 1'b1;
    sb.push_back(mk(2'd1, 32'hBAD0_0001, 1'b1));
    slave_read(32'h8000_3000, 1, 32'hBAD0_0001, 2'b10, 0);
    cyc();
    m_rvalid = 1'b0; m_rresp = 2'b00; lsu_arvalid = 1'b0;

    // Store and load requested together: store first, load on the next grant
    lsu_awaddr = 32'h8000_4000; lsu_wdata = 32'hCAFE_F00D; lsu_wstrb = 4'b1000; lsu_wvalid = 1'b1;
    lsu_araddr = 32'h8000_5000; lsu_arvalid = 1'b1;
    sb.push_back(mk(2'd2, 32'h0, 1'b0));
    sb.push_back(mk(2'd1, 32'h1122_3344, 1'b0));
    slave_write(32'h8000_4000, 32'hCAFE_F00D, 4'b1000, 0, 0, 2'b00);
    cyc();
    m_bvalid = 1'b0; lsu_wvalid = 1'b0;
    slave_read(32'h8000_5000, 0, 32'h1122_3344, 2'b00, 1);
    cyc();
    m_rvalid = 1'b0; lsu_arvalid = 1'b0;

    // Reset while waiting in IFU_R: no pulse, everything back to idle
    ifu_araddr = 32'h8000_0100; ifu_arvalid = 1'b1;
    #2;
    chk("rq_cycle_n", {63'd0, m_arvalid}, 64'd0);
    cyc();
    #2;
    chk("rq_cycle_n1", {32'd0, m_arvalid, m_araddr[30:0]}, {32'd0, 1'b1, 31'h0000_0100});
    m_arready = 1'b1;
    cyc();
    m_arready = 1'b0;
    #2;
    chk("in_ifu_r", {63'd0, m_rready}, 64'd1);
    rst = 1'b1; ifu_arvalid = 1'b0;
    m_rdata = 32'hFFFF_0000; m_rvalid = 1'b1;
    #1;
    chk("rst_no_pulse", {62'd0, ifu_rvalid, ifu_err}, 64'd0);
    cyc();
    rst = 1'b0;
    #2;
    chk("rst_mid_valids", {59'd0, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 64'd0);
    chk("rst_mid_upstream", {61'd0, ifu_rvalid, lsu_rvalid, lsu_bvalid}, 64'd0);
    cyc();
    m_rvalid = 1'b0;
    #2;
    chk("rst_mid_idle", {63'd0, m_arvalid}, 64'd0);

    // Normal fetch after the mid-transaction reset
    cyc();
    ifu_araddr = 32'h8000_0200; ifu_arvalid = 1'b1;
    sb.push_back(mk(2'd0, 32'h0050_0093, 1'b0));
    slave_read(32'h8000_0200, 0, 32'h0050_0093, 2'b00, 0);
    cyc();
    m_rvalid = 1'b0; ifu_arvalid = 1'b0;

    cyc();
    cyc();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
